// File: rtl/ts_pkg.sv
// Shared constants and state encoding for the MPEG-TS packet aligner.
package ts_pkg;
    localparam int         TS_PKT_LEN = 188;
    localparam logic [7:0] TS_SYNC    = 8'h47;
    localparam int         BYTE_MSB   = 7;
    localparam int         DVALID_BIT = 8;
    localparam int         PSYNC_BIT  = 9;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } ts_state_e;
endpackage

// File: rtl/ts_sync_counter.sv
// Byte position counter plus hit/miss counters for the TS aligner.
// Strobes are combinational on the current word; counters only move on valid bytes.
module ts_sync_counter
    import ts_pkg::*;
#(
    parameter int         PKT_LEN   = TS_PKT_LEN,
    parameter logic [7:0] SYNC_BYTE = TS_SYNC,
    parameter int         LOCK_CNT  = 3,
    parameter int         LOSS_CNT  = 3
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    input  logic       i_verify,
    input  logic       i_locked,
    input  logic       i_load,
    input  logic       i_clear,
    output logic [7:0] o_pos,
    output logic       o_at_sync,
    output logic       o_hit,
    output logic       o_miss,
    output logic       o_lock_reached,
    output logic       o_loss_reached
);
    localparam logic [7:0] LAST_POS = 8'(PKT_LEN - 1);

    logic [7:0] r_pos;
    logic [7:0] r_hit_cnt;
    logic [7:0] r_miss_cnt;
    logic       w_is_sync;

    assign w_is_sync      = (i_byte == SYNC_BYTE);
    assign o_pos          = r_pos;
    assign o_at_sync      = (r_pos == 8'd0);
    assign o_hit          = i_valid && o_at_sync && w_is_sync;
    assign o_miss         = i_valid && o_at_sync && !w_is_sync;
    // Thresholds describe what the count would become if this byte is a hit/miss.
    assign o_lock_reached = (int'(r_hit_cnt) + 1 >= LOCK_CNT);
    assign o_loss_reached = (int'(r_miss_cnt) + 1 >= LOSS_CNT);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pos      <= 8'd0;
            r_hit_cnt  <= 8'd0;
            r_miss_cnt <= 8'd0;
        end else if (i_valid) begin
            if (i_load)
                r_pos <= 8'd1;
            else if (r_pos == LAST_POS)
                r_pos <= 8'd0;
            else
                r_pos <= r_pos + 8'd1;

            if (i_clear) begin
                r_hit_cnt  <= 8'd0;
                r_miss_cnt <= 8'd0;
            end else if (i_load) begin
                r_hit_cnt  <= 8'd1;
                r_miss_cnt <= 8'd0;
            end else if (i_verify && o_hit) begin
                r_hit_cnt  <= r_hit_cnt + 8'd1;
            end else if (i_locked && o_hit) begin
                r_miss_cnt <= 8'd0;
            end else if (i_locked && o_miss) begin
                r_miss_cnt <= r_miss_cnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/ts_packet_aligner.sv
// MPEG-TS packet aligner: hunts for the sync byte, verifies the 188-byte period,
// then emits aligned packet bytes with SOP/EOP/ERR flags until lock is lost.
module ts_packet_aligner
    import ts_pkg::*;
#(
    parameter int         PKT_LEN   = TS_PKT_LEN,
    parameter logic [7:0] SYNC_BYTE = TS_SYNC,
    parameter int         LOCK_CNT  = 3,
    parameter int         LOSS_CNT  = 3
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [9:0]  i_data_in,
    output logic [7:0]  o_pkt_data,
    output logic        o_pkt_valid,
    output logic        o_pkt_sop,
    output logic        o_pkt_eop,
    output logic        o_pkt_err,
    output logic        o_locked,
    output logic [15:0] o_pkt_count
);
    localparam logic [7:0] LAST_POS = 8'(PKT_LEN - 1);

    ts_state_e   r_state;
    logic [7:0]  r_pkt_data;
    logic        r_pkt_valid;
    logic        r_pkt_sop;
    logic        r_pkt_eop;
    logic        r_pkt_err;
    logic        r_locked;
    logic [15:0] r_pkt_count;
    logic        r_psync_seen;

    logic       w_valid;
    logic [7:0] w_byte;
    logic       w_psync;
    logic [7:0] w_pos;
    logic       w_at_sync;
    logic       w_hit;
    logic       w_miss;
    logic       w_lock_reached;
    logic       w_loss_reached;
    logic       w_load;
    logic       w_clear;
    logic       w_enter_lock;
    logic       w_emit;
    logic       w_sop;
    logic       w_eop;
    logic       w_err;

    assign w_valid = i_data_in[DVALID_BIT];
    assign w_byte  = i_data_in[BYTE_MSB:0];
    assign w_psync = i_data_in[PSYNC_BIT];

    ts_sync_counter #(
        .PKT_LEN   (PKT_LEN),
        .SYNC_BYTE (SYNC_BYTE),
        .LOCK_CNT  (LOCK_CNT),
        .LOSS_CNT  (LOSS_CNT)
    ) u_sync_counter (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_valid        (w_valid),
        .i_byte         (w_byte),
        .i_verify       (r_state == VERIFY),
        .i_locked       (r_state == LOCKED),
        .i_load         (w_load),
        .i_clear        (w_clear),
        .o_pos          (w_pos),
        .o_at_sync      (w_at_sync),
        .o_hit          (w_hit),
        .o_miss         (w_miss),
        .o_lock_reached (w_lock_reached),
        .o_loss_reached (w_loss_reached)
    );

    assign w_load       = (r_state == HUNT) && w_valid && (w_byte == SYNC_BYTE);
    assign w_clear      = ((r_state == VERIFY) && w_miss) ||
                          ((r_state == LOCKED) && w_miss && w_loss_reached);
    assign w_enter_lock = (w_load && (LOCK_CNT <= 1)) ||
                          ((r_state == VERIFY) && w_hit && w_lock_reached);
    assign w_emit       = w_enter_lock ||
                          ((r_state == LOCKED) && w_valid && !(w_miss && w_loss_reached));
    assign w_sop        = w_enter_lock || ((r_state == LOCKED) && w_at_sync);
    assign w_eop        = (r_state == LOCKED) && (w_pos == LAST_POS);
    // A stray PSYNC is only meaningful once a period is being tracked.
    assign w_err        = w_sop && (((r_state == LOCKED) && w_miss) || !w_psync ||
                                    ((r_state != HUNT) && r_psync_seen));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= HUNT;
            r_pkt_data   <= 8'd0;
            r_pkt_valid  <= 1'b0;
            r_pkt_sop    <= 1'b0;
            r_pkt_eop    <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_locked     <= 1'b0;
            r_pkt_count  <= 16'd0;
            r_psync_seen <= 1'b0;
        end else begin
            r_pkt_valid <= 1'b0;
            r_pkt_sop   <= 1'b0;
            r_pkt_eop   <= 1'b0;
            r_pkt_err   <= 1'b0;
            if (w_valid) begin
                case (r_state)
                    HUNT: begin
                        if (w_load) begin
                            if (LOCK_CNT <= 1) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_state  <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (w_miss) begin
                            r_state <= HUNT;
                        end else if (w_hit && w_lock_reached) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (w_miss && w_loss_reached) begin
                            r_state  <= HUNT;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase

                if (w_emit) begin
                    r_pkt_data  <= w_byte;
                    r_pkt_valid <= 1'b1;
                    r_pkt_sop   <= w_sop;
                    r_pkt_eop   <= w_eop;
                    r_pkt_err   <= w_err;
                    if (w_eop)
                        r_pkt_count <= r_pkt_count + 16'd1;
                end

                if ((r_state != HUNT) && w_psync && !w_at_sync)
                    r_psync_seen <= 1'b1;
                else if ((r_state == HUNT) || w_at_sync)
                    r_psync_seen <= 1'b0;
            end
        end
    end

    assign o_pkt_data  = r_pkt_data;
    assign o_pkt_valid = r_pkt_valid;
    assign o_pkt_sop   = r_pkt_sop;
    assign o_pkt_eop   = r_pkt_eop;
    assign o_pkt_err   = r_pkt_err;
    assign o_locked    = r_locked;
    assign o_pkt_count = r_pkt_count;
endmodule

// File: tb/tb_ts_packet_aligner.sv
// Directed bench for ts_packet_aligner: inputs change on the falling edge,
// a monitor samples outputs 1ns after each rising edge and tallies packet events.
module tb_ts_packet_aligner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  din = 10'd0;
    logic [7:0]  o_pkt_data;
    logic        o_pkt_valid, o_pkt_sop, o_pkt_eop, o_pkt_err, o_locked;
    logic [15:0] o_pkt_count;

    always #5 clk = ~clk;

    ts_packet_aligner dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_data_in   (din),
        .o_pkt_data  (o_pkt_data),
        .o_pkt_valid (o_pkt_valid),
        .o_pkt_sop   (o_pkt_sop),
        .o_pkt_eop   (o_pkt_eop),
        .o_pkt_err   (o_pkt_err),
        .o_locked    (o_locked),
        .o_pkt_count (o_pkt_count)
    );

    localparam int S_VALID = 0, S_SOP = 1, S_EOP = 2, S_ERR = 3, S_ERRBAD = 4,
                   S_DATABAD = 5, S_EOPBAD = 6, S_LOCKBAD = 7, S_GAPBAD = 8;

    int n_checks = 0;
    int n_fail   = 0;
    int stat [9] = '{default: 0};
    int base [9] = '{default: 0};
    int mon_pos  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Payload is the byte index, with 0x47 blanked so it never looks like a sync.
    function automatic logic [7:0] payload(input int i);
        payload = (i == 32'h47) ? 8'h00 : 8'(i);
    endfunction

    function automatic int delta(input int k);
        delta = stat[k] - base[k];
    endfunction

    task automatic snap();
        for (int k = 0; k < 9; k++) base[k] = stat[k];
    endtask

    always @(posedge clk) begin
        #1;
        if (o_pkt_valid) begin
            stat[S_VALID]++;
            if (!din[8]) stat[S_GAPBAD]++;
            if (o_pkt_sop) begin
                stat[S_SOP]++;
                mon_pos = 0;
                if (o_pkt_err) stat[S_ERR]++;
                if (o_pkt_err != (o_pkt_data != 8'h47)) stat[S_ERRBAD]++;
                if (!o_locked) stat[S_LOCKBAD]++;
            end else begin
                mon_pos++;
                if (o_pkt_data != payload(mon_pos)) stat[S_DATABAD]++;
            end
            if (o_pkt_eop) begin
                stat[S_EOP]++;
                if (mon_pos != 187) stat[S_EOPBAD]++;
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic ps, input logic v);
        @(negedge clk);
        din = {ps, v, b};
    endtask

    task automatic idle(input int n);
        repeat (n) send(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_pkt(input logic [7:0] sync, input int start, input int stop,
                            input int false_off, input bit gaps);
        for (int i = start; i < stop; i++) begin
            if (gaps) send(8'h47, 1'b1, 1'b0);
            if (i == 0)              send(sync, 1'b1, 1'b1);
            else if (i == false_off) send(8'h47, 1'b0, 1'b1);
            else                     send(payload(i), 1'b0, 1'b1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din = 10'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset, then idle input
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(20);
        check_eq("rst_valid", o_pkt_valid, 0);
        check_eq("rst_sop",   o_pkt_sop, 0);
        check_eq("rst_data",  o_pkt_data, 0);
        check_eq("rst_locked", o_locked, 0);
        check_eq("rst_count", o_pkt_count, 0);

        // Four clean packets: lock on the third sync
        snap();
        repeat (4) send_pkt(8'h47, 0, 188, -1, 1'b0);
        idle(1);
        check_eq("clean_sop",     delta(S_SOP), 2);
        check_eq("clean_eop",     delta(S_EOP), 2);
        check_eq("clean_valid",   delta(S_VALID), 376);
        check_eq("clean_err",     delta(S_ERR), 0);
        check_eq("clean_data",    delta(S_DATABAD), 0);
        check_eq("clean_eoppos",  delta(S_EOPBAD), 0);
        check_eq("clean_lockatsop", delta(S_LOCKBAD), 0);
        check_eq("clean_locked",  o_locked, 1);
        check_eq("clean_count",   o_pkt_count, 2);

        // One corrupted sync while locked
        snap();
        send_pkt(8'h48, 0, 188, -1, 1'b0);
        send_pkt(8'h47, 0, 188, -1, 1'b0);
        idle(1);
        check_eq("bad1_sop",    delta(S_SOP), 2);
        check_eq("bad1_err",    delta(S_ERR), 1);
        check_eq("bad1_errpos", delta(S_ERRBAD), 0);
        check_eq("bad1_locked", o_locked, 1);
        check_eq("bad1_count",  o_pkt_count, 4);

        // Three corrupted syncs drop lock, then relock
        snap();
        send_pkt(8'h48, 0, 188, -1, 1'b0);
        send_pkt(8'h48, 0, 188, -1, 1'b0);
        send(8'h48, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_eq("loss_locked", o_locked, 0);
        check_eq("loss_valid",  o_pkt_valid, 0);
        send_pkt(8'h48, 1, 188, -1, 1'b0);
        repeat (4) send_pkt(8'h47, 0, 188, -1, 1'b0);
        idle(1);
        check_eq("loss_sop",     delta(S_SOP), 4);
        check_eq("loss_eop",     delta(S_EOP), 4);
        check_eq("loss_err",     delta(S_ERR), 2);
        check_eq("loss_valid_n", delta(S_VALID), 752);
        check_eq("loss_errpos",  delta(S_ERRBAD), 0);
        check_eq("relock",       o_locked, 1);
        check_eq("loss_count",   o_pkt_count, 8);

        // DVALID gaps every other cycle
        snap();
        repeat (2) send_pkt(8'h47, 0, 188, -1, 1'b1);
        idle(1);
        check_eq("gap_sop",    delta(S_SOP), 2);
        check_eq("gap_eop",    delta(S_EOP), 2);
        check_eq("gap_valid",  delta(S_VALID), 376);
        check_eq("gap_idleout", delta(S_GAPBAD), 0);
        check_eq("gap_data",   delta(S_DATABAD), 0);
        check_eq("gap_eoppos", delta(S_EOPBAD), 0);
        check_eq("gap_count",  o_pkt_count, 10);

        // False sync at offset 50 while hunting
        do_reset();
        check_eq("rst2_count", o_pkt_count, 0);
        snap();
        send_pkt(8'h47, 1, 188, 50, 1'b0);
        repeat (3) send_pkt(8'h47, 0, 188, -1, 1'b0);
        check_eq("false_nolock", o_locked, 0);
        check_eq("false_nosop",  delta(S_SOP), 0);
        send_pkt(8'h47, 0, 188, -1, 1'b0);
        idle(1);
        check_eq("false_sop",    delta(S_SOP), 1);
        check_eq("false_eop",    delta(S_EOP), 1);
        check_eq("false_locked", o_locked, 1);
        check_eq("false_count",  o_pkt_count, 1);
        check_eq("false_data",   delta(S_DATABAD), 0);

        // Reset in the middle of a packet
        send_pkt(8'h47, 0, 100, -1, 1'b0);
        @(posedge clk);
        #1;
        check_eq("mid_valid_pre", o_pkt_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        din = 10'd0;
        @(posedge clk);
        #1;
        check_eq("mid_valid",  o_pkt_valid, 0);
        check_eq("mid_sop",    o_pkt_sop, 0);
        check_eq("mid_data",   o_pkt_data, 0);
        check_eq("mid_locked", o_locked, 0);
        check_eq("mid_count",  o_pkt_count, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
